// File: rtl/sys_defs.sv
// Shared types for the instruction-side MSHR: entry/fill records, memory tag and block widths.
`ifndef ICACHE_MSHR_ENTRIES
`define ICACHE_MSHR_ENTRIES 4
`endif

package sys_defs;

    localparam int MEM_TAG_BITS        = 4;
    localparam int MEM_BLOCK_BITS      = 64;
    localparam int ICACHE_MSHR_ENTRIES = `ICACHE_MSHR_ENTRIES;

    typedef logic [MEM_TAG_BITS-1:0]   MEM_TAG;
    typedef logic [MEM_BLOCK_BITS-1:0] MEM_BLOCK;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        ALLOC = 2'd1,
        WAIT  = 2'd2
    } IMSHR_STATE;

    typedef struct packed {
        IMSHR_STATE  state;
        logic [31:0] line_addr;
        MEM_TAG      mem_tag;
        logic        demand;
    } IMSHR_ENTRY;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        MEM_BLOCK    data;
        logic        is_prefetch;
    } IMSHR_FILL;

    function automatic logic [31:0] line_of(input logic [31:0] addr, input int unsigned off_bits);
        return addr >> off_bits;
    endfunction

endpackage

// File: rtl/imshr_pick.sv
// Lowest-index picker: one-hot of the first set request bit and its binary index.
module imshr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
)(
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx
);

    logic [N-1:0] w_lower;

    assign w_lower[0] = 1'b0;
    for (genvar gi = 1; gi < N; gi++) begin : g_lower
        assign w_lower[gi] = w_lower[gi-1] | i_req[gi-1];
    end

    assign o_onehot = i_req & ~w_lower;

    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/icache_miss_handler.sv
// Instruction-side MSHR: merges demand/prefetch misses, issues one line request per cycle, fills on tag return.
// Define ICACHE_MSHR_FILL_BYPASS_EN to drive fill_* combinationally in the return cycle.
module icache_miss_handler
    import sys_defs::*;
#(
    parameter int NUM_ENTRIES   = ICACHE_MSHR_ENTRIES,
    parameter int NUM_SNOOP     = 2,
    parameter int LINE_OFF_BITS = 3,
    parameter int PF_RESERVE    = 1
)(
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 demand_valid,
    input  logic [31:0]                          demand_addr,
    output logic                                 demand_ready,
    input  logic                                 pf_valid,
    input  logic [31:0]                          pf_addr,
    output logic                                 pf_ready,
    input  logic [NUM_SNOOP-1:0][31:0]           snoop_addr,
    output logic [NUM_SNOOP-1:0]                 snoop_hit,
    output logic                                 mem_req_valid,
    output logic [31:0]                          mem_req_addr,
    input  logic                                 mem_req_accepted,
    input  MEM_TAG                               current_req_tag,
    input  MEM_BLOCK                             return_data,
    input  MEM_TAG                               return_data_tag,
    output logic                                 fill_valid,
    output logic [31:0]                          fill_addr,
    output MEM_BLOCK                             fill_data,
    output logic                                 fill_is_prefetch,
    output logic                                 full,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]     occupancy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

    IMSHR_ENTRY r_entry      [NUM_ENTRIES];
    IMSHR_ENTRY w_entry_next [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] w_free, w_alloc, w_alloc_dem, w_dmatch, w_pmatch, w_ret_hit;
    logic [NUM_ENTRIES-1:0] w_d_oh, w_p_oh, w_p_mask, w_id_oh, w_ia_oh;
    logic [IDX_W-1:0]       w_d_idx, w_p_idx, w_id_idx, w_ia_idx, w_iss_idx;
    logic [31:0]            w_dline, w_pline;
    logic [OCC_W-1:0]       w_free_cnt;
    logic                   w_accept_ok, w_dmerge, w_d_alloc, w_pf_same, w_pmerge, w_pf_room, w_p_alloc;
    logic                   w_issue;
    IMSHR_FILL              w_fill, w_fill_out;

    assign w_dline     = line_of(demand_addr, LINE_OFF_BITS);
    assign w_pline     = line_of(pf_addr, LINE_OFF_BITS);
    assign w_accept_ok = !reset && !flush;

    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
        assign w_free[gi]      = r_entry[gi].state == FREE;
        assign w_alloc[gi]     = r_entry[gi].state == ALLOC;
        assign w_alloc_dem[gi] = w_alloc[gi] && r_entry[gi].demand;
        assign w_dmatch[gi]    = !w_free[gi] && r_entry[gi].line_addr == w_dline;
        assign w_pmatch[gi]    = !w_free[gi] && r_entry[gi].line_addr == w_pline;
        assign w_ret_hit[gi]   = !reset && r_entry[gi].state == WAIT && return_data_tag != '0
                                 && r_entry[gi].mem_tag == return_data_tag;
    end

    // Snoop only sees registered state, so a same-cycle allocation is invisible here.
    for (genvar gi = 0; gi < NUM_SNOOP; gi++) begin : g_snoop
        logic [NUM_ENTRIES-1:0] w_smatch;
        for (genvar gj = 0; gj < NUM_ENTRIES; gj++) begin : g_cmp
            assign w_smatch[gj] = !w_free[gj]
                                  && r_entry[gj].line_addr == line_of(snoop_addr[gi], LINE_OFF_BITS);
        end
        assign snoop_hit[gi] = |w_smatch;
    end

    imshr_pick #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_pick_demand (.i_req(w_free),      .o_onehot(w_d_oh),  .o_idx(w_d_idx));
    imshr_pick #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_pick_pf     (.i_req(w_p_mask),    .o_onehot(w_p_oh),  .o_idx(w_p_idx));
    imshr_pick #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_pick_iss_d  (.i_req(w_alloc_dem), .o_onehot(w_id_oh), .o_idx(w_id_idx));
    imshr_pick #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_pick_iss_a  (.i_req(w_alloc),     .o_onehot(w_ia_oh), .o_idx(w_ia_idx));

    always_comb begin
        w_free_cnt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_free_cnt = w_free_cnt + OCC_W'(w_free[i]);
        end
    end

    assign w_dmerge     = |w_dmatch;
    assign w_d_alloc    = w_accept_ok && demand_valid && !w_dmerge && |w_d_oh;
    assign demand_ready = w_accept_ok && demand_valid && (w_dmerge || |w_d_oh);

    // The prefetch sees the free pool after the demand has taken its slot.
    assign w_p_mask  = w_free & ~(w_d_alloc ? w_d_oh : '0);
    assign w_pf_same = w_d_alloc && w_pline == w_dline;
    assign w_pmerge  = |w_pmatch || w_pf_same;
    assign w_pf_room = (int'(w_free_cnt) - int'(w_d_alloc)) > PF_RESERVE;
    assign w_p_alloc = w_accept_ok && pf_valid && !w_pmerge && |w_p_oh && w_pf_room;
    assign pf_ready  = w_accept_ok && pf_valid && (w_pmerge || (|w_p_oh && w_pf_room));

    assign w_iss_idx     = |w_id_oh ? w_id_idx : w_ia_idx;
    assign mem_req_valid = w_accept_ok && |w_ia_oh;
    assign mem_req_addr  = r_entry[w_iss_idx].line_addr << LINE_OFF_BITS;
    assign w_issue       = mem_req_valid && mem_req_accepted && current_req_tag != '0;

    // A demand merging into the line being returned this cycle still counts as demand.
    always_comb begin
        w_fill = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_ret_hit[i]) begin
                w_fill.valid       = 1'b1;
                w_fill.addr        = r_entry[i].line_addr << LINE_OFF_BITS;
                w_fill.data        = return_data;
                w_fill.is_prefetch = !(r_entry[i].demand || (w_dmatch[i] && demand_valid && w_accept_ok));
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_entry_next[i] = r_entry[i];
            if (flush) begin
                if (r_entry[i].state == ALLOC) w_entry_next[i].state = FREE;
                w_entry_next[i].demand = 1'b0;
            end else if (demand_valid && w_dmatch[i]) begin
                w_entry_next[i].demand = 1'b1;
            end
            if (w_issue && w_iss_idx == IDX_W'(i)) begin
                w_entry_next[i].state   = WAIT;
                w_entry_next[i].mem_tag = current_req_tag;
            end
            if (w_ret_hit[i]) begin
                w_entry_next[i].state  = FREE;
                w_entry_next[i].demand = 1'b0;
            end
        end
        if (w_d_alloc) w_entry_next[w_d_idx] = '{state: ALLOC, line_addr: w_dline, mem_tag: '0, demand: 1'b1};
        if (w_p_alloc) w_entry_next[w_p_idx] = '{state: ALLOC, line_addr: w_pline, mem_tag: '0, demand: 1'b0};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) r_entry[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) r_entry[i] <= w_entry_next[i];
        end
    end

`ifdef ICACHE_MSHR_FILL_BYPASS_EN
    assign w_fill_out = w_fill;
`else
    IMSHR_FILL r_fill;
    always_ff @(posedge clock) begin
        if (reset) r_fill <= '0;
        else       r_fill <= w_fill;
    end
    assign w_fill_out = r_fill;
`endif

    assign fill_valid       = w_fill_out.valid;
    assign fill_addr        = w_fill_out.addr;
    assign fill_data        = w_fill_out.data;
    assign fill_is_prefetch = w_fill_out.is_prefetch;

    assign full      = ~|w_free;
    assign occupancy = OCC_W'(NUM_ENTRIES) - w_free_cnt;

endmodule

// File: tb/tb_icache_miss_handler.sv
// Directed bench for icache_miss_handler (default build, registered fill).
module tb_icache_miss_handler;
    import sys_defs::*;

    localparam int NS = 2;

    logic              clock = 1'b0;
    logic              reset, flush;
    logic              demand_valid, pf_valid;
    logic [31:0]       demand_addr, pf_addr;
    logic              demand_ready, pf_ready;
    logic [NS-1:0][31:0] snoop_addr;
    logic [NS-1:0]     snoop_hit;
    logic              mem_req_valid, mem_req_accepted;
    logic [31:0]       mem_req_addr;
    MEM_TAG            current_req_tag, return_data_tag;
    MEM_BLOCK          return_data, fill_data;
    logic              fill_valid, fill_is_prefetch, full;
    logic [31:0]       fill_addr;
    logic [2:0]        occupancy;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    icache_miss_handler #(.NUM_ENTRIES(4), .NUM_SNOOP(NS), .LINE_OFF_BITS(3), .PF_RESERVE(1)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .demand_valid(demand_valid), .demand_addr(demand_addr), .demand_ready(demand_ready),
        .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_ready(pf_ready),
        .snoop_addr(snoop_addr), .snoop_hit(snoop_hit),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_accepted(mem_req_accepted), .current_req_tag(current_req_tag),
        .return_data(return_data), .return_data_tag(return_data_tag),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .fill_is_prefetch(fill_is_prefetch), .full(full), .occupancy(occupancy)
    );

    task automatic idle();
        flush = 0; demand_valid = 0; demand_addr = 0; pf_valid = 0; pf_addr = 0;
        mem_req_accepted = 0; current_req_tag = 0; return_data = 0; return_data_tag = 0;
    endtask

    task automatic test_reset();
        idle(); snoop_addr = '0; reset = 1; demand_valid = 1; demand_addr = 32'h40;
        @(negedge clock); #1;
        checks++; if (demand_ready !== 1'b0) begin errors++; $display("FAIL reset_dready got=%0b exp=0", demand_ready); end
        @(posedge clock); @(negedge clock); reset = 0; demand_valid = 0; #1;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_reqv got=%0b exp=0", mem_req_valid); end
        checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_reqa got=%h exp=0", mem_req_addr); end
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL reset_fillv got=%0b exp=0", fill_valid); end
        checks++; if (snoop_hit !== 2'b00) begin errors++; $display("FAIL reset_snoop got=%b exp=00", snoop_hit); end
        $display("test_reset: done");
    endtask

    task automatic test_demand_fill();
        @(negedge clock); idle(); demand_valid = 1; demand_addr = 32'h100; #1;
        checks++; if (demand_ready !== 1'b1) begin errors++; $display("FAIL df_dready got=%0b exp=1", demand_ready); end
        @(posedge clock); #1;
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL df_occ1 got=%0d exp=1", occupancy); end
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL df_reqv got=%0b exp=1", mem_req_valid); end
        checks++; if (mem_req_addr !== 32'h100) begin errors++; $display("FAIL df_reqa got=%h exp=100", mem_req_addr); end
        @(negedge clock); idle(); mem_req_accepted = 1; current_req_tag = 3;
        @(posedge clock); #1;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL df_reqv_wait got=%0b exp=0", mem_req_valid); end
        @(negedge clock); idle(); return_data_tag = 3; return_data = 64'hDEAD; #1;
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL df_fill_early got=%0b exp=0", fill_valid); end
        @(posedge clock); #1;
        checks++; if (fill_valid !== 1'b1) begin errors++; $display("FAIL df_fillv got=%0b exp=1", fill_valid); end
        checks++; if (fill_addr !== 32'h100) begin errors++; $display("FAIL df_filla got=%h exp=100", fill_addr); end
        checks++; if (fill_data !== 64'hDEAD) begin errors++; $display("FAIL df_filld got=%h exp=dead", fill_data); end
        checks++; if (fill_is_prefetch !== 1'b0) begin errors++; $display("FAIL df_fillpf got=%0b exp=0", fill_is_prefetch); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL df_occ0 got=%0d exp=0", occupancy); end
        @(negedge clock); idle(); @(posedge clock); #1;
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL df_fill_hold got=%0b exp=0", fill_valid); end
        $display("test_demand_fill: demand 0x100 tag 3 -> fill 0x%h", 32'h100);
    endtask

    task automatic test_merge();
        @(negedge clock); idle(); pf_valid = 1; pf_addr = 32'h200; #1;
        checks++; if (pf_ready !== 1'b1) begin errors++; $display("FAIL mg_pready got=%0b exp=1", pf_ready); end
        @(posedge clock);
        @(negedge clock); idle(); snoop_addr[0] = 32'h204; snoop_addr[1] = 32'h300;
        demand_valid = 1; demand_addr = 32'h204; #1;
        checks++; if (demand_ready !== 1'b1) begin errors++; $display("FAIL mg_dready got=%0b exp=1", demand_ready); end
        checks++; if (snoop_hit !== 2'b01) begin errors++; $display("FAIL mg_snoop got=%b exp=01", snoop_hit); end
        checks++; if (mem_req_addr !== 32'h200) begin errors++; $display("FAIL mg_reqa got=%h exp=200", mem_req_addr); end
        @(posedge clock); #1;
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL mg_occ got=%0d exp=1", occupancy); end
        @(negedge clock); idle(); snoop_addr = '0; mem_req_accepted = 1; current_req_tag = 4;
        @(posedge clock);
        @(negedge clock); idle(); return_data_tag = 4; return_data = 64'h1234;
        @(posedge clock); #1;
        checks++; if (fill_valid !== 1'b1) begin errors++; $display("FAIL mg_fillv got=%0b exp=1", fill_valid); end
        checks++; if (fill_addr !== 32'h200) begin errors++; $display("FAIL mg_filla got=%h exp=200", fill_addr); end
        checks++; if (fill_is_prefetch !== 1'b0) begin errors++; $display("FAIL mg_fillpf got=%0b exp=0", fill_is_prefetch); end
        $display("test_merge: prefetch 0x200 + demand 0x204 merged");
    endtask

    task automatic test_pf_reserve();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); idle(); pf_valid = 1; pf_addr = 32'h10 * (k + 1); #1;
            checks++; if (pf_ready !== 1'b1) begin errors++; $display("FAIL pr_pready%0d got=%0b exp=1", k, pf_ready); end
            @(posedge clock);
        end
        @(negedge clock); idle(); pf_valid = 1; pf_addr = 32'h50; #1;
        checks++; if (pf_ready !== 1'b0) begin errors++; $display("FAIL pr_reserve got=%0b exp=0", pf_ready); end
        @(posedge clock); #1;
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL pr_occ3 got=%0d exp=3", occupancy); end
        @(negedge clock); idle(); demand_valid = 1; demand_addr = 32'h40; #1;
        checks++; if (demand_ready !== 1'b1) begin errors++; $display("FAIL pr_dready got=%0b exp=1", demand_ready); end
        @(posedge clock); #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL pr_full got=%0b exp=1", full); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL pr_occ4 got=%0d exp=4", occupancy); end
        checks++; if (mem_req_addr !== 32'h40) begin errors++; $display("FAIL pr_prio got=%h exp=40", mem_req_addr); end
        @(negedge clock); idle(); demand_valid = 1; demand_addr = 32'h60; #1;
        checks++; if (demand_ready !== 1'b0) begin errors++; $display("FAIL pr_dfull got=%0b exp=0", demand_ready); end
        demand_addr = 32'h20; #1;
        checks++; if (demand_ready !== 1'b1) begin errors++; $display("FAIL pr_dmerge got=%0b exp=1", demand_ready); end
        @(posedge clock); #1;
        checks++; if (mem_req_addr !== 32'h20) begin errors++; $display("FAIL pr_prio2 got=%h exp=20", mem_req_addr); end
        @(negedge clock); idle(); flush = 1; demand_valid = 1; demand_addr = 32'h20; pf_valid = 1; pf_addr = 32'h80; #1;
        checks++; if (demand_ready !== 1'b0) begin errors++; $display("FAIL pr_fl_dready got=%0b exp=0", demand_ready); end
        checks++; if (pf_ready !== 1'b0) begin errors++; $display("FAIL pr_fl_pready got=%0b exp=0", pf_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL pr_fl_reqv got=%0b exp=0", mem_req_valid); end
        @(posedge clock); #1;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL pr_fl_occ got=%0d exp=0", occupancy); end
        $display("test_pf_reserve: 3 prefetches, 4th refused, demand fills last slot");
    endtask

    task automatic test_out_of_order();
        @(negedge clock); idle(); demand_valid = 1; demand_addr = 32'h400;
        @(posedge clock);
        @(negedge clock); idle(); demand_valid = 1; demand_addr = 32'h500; mem_req_accepted = 1; current_req_tag = 1; #1;
        checks++; if (mem_req_addr !== 32'h400) begin errors++; $display("FAIL oo_req1 got=%h exp=400", mem_req_addr); end
        @(posedge clock);
        @(negedge clock); idle(); mem_req_accepted = 1; current_req_tag = 2; #1;
        checks++; if (mem_req_addr !== 32'h500) begin errors++; $display("FAIL oo_req2 got=%h exp=500", mem_req_addr); end
        @(posedge clock); #1;
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL oo_occ2 got=%0d exp=2", occupancy); end
        @(negedge clock); idle(); return_data_tag = 2; return_data = 64'hB2;
        @(posedge clock); #1;
        checks++; if (fill_addr !== 32'h500) begin errors++; $display("FAIL oo_fill2a got=%h exp=500", fill_addr); end
        checks++; if (fill_data !== 64'hB2) begin errors++; $display("FAIL oo_fill2d got=%h exp=b2", fill_data); end
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL oo_occ1 got=%0d exp=1", occupancy); end
        @(negedge clock); idle(); return_data_tag = 1; return_data = 64'hB1;
        @(posedge clock); #1;
        checks++; if (fill_valid !== 1'b1) begin errors++; $display("FAIL oo_fill1v got=%0b exp=1", fill_valid); end
        checks++; if (fill_addr !== 32'h400) begin errors++; $display("FAIL oo_fill1a got=%h exp=400", fill_addr); end
        @(negedge clock); idle(); return_data_tag = 5;
        @(posedge clock); #1;
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL oo_unknown got=%0b exp=0", fill_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL oo_occ0 got=%0d exp=0", occupancy); end
        $display("test_out_of_order: tags 1,2 returned as 2,1; tag 5 ignored");
    endtask

    task automatic test_retry();
        @(negedge clock); idle(); demand_valid = 1; demand_addr = 32'h600;
        @(posedge clock);
        @(negedge clock); idle(); mem_req_accepted = 1; current_req_tag = 0;
        @(posedge clock); #1;
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rt_reqv got=%0b exp=1", mem_req_valid); end
        checks++; if (mem_req_addr !== 32'h600) begin errors++; $display("FAIL rt_reqa got=%h exp=600", mem_req_addr); end
        @(negedge clock); idle(); mem_req_accepted = 1; current_req_tag = 6;
        @(posedge clock); #1;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rt_issued got=%0b exp=0", mem_req_valid); end
        @(negedge clock); idle(); return_data_tag = 6; return_data = 64'h66;
        @(posedge clock); #1;
        checks++; if (fill_addr !== 32'h600) begin errors++; $display("FAIL rt_filla got=%h exp=600", fill_addr); end
        $display("test_retry: tag 0 rejected, reissued with tag 6");
    endtask

    task automatic test_flush();
        @(negedge clock); idle(); demand_valid = 1; demand_addr = 32'h700;
        @(posedge clock);
        @(negedge clock); idle(); mem_req_accepted = 1; current_req_tag = 7; pf_valid = 1; pf_addr = 32'h800; #1;
        checks++; if (pf_ready !== 1'b1) begin errors++; $display("FAIL fl_pready got=%0b exp=1", pf_ready); end
        @(posedge clock); #1;
        checks++; if (mem_req_addr !== 32'h800) begin errors++; $display("FAIL fl_reqa got=%h exp=800", mem_req_addr); end
        @(negedge clock); idle(); flush = 1; demand_valid = 1; demand_addr = 32'h900; #1;
        checks++; if (demand_ready !== 1'b0) begin errors++; $display("FAIL fl_dready got=%0b exp=0", demand_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL fl_reqv got=%0b exp=0", mem_req_valid); end
        @(posedge clock); #1;
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL fl_occ got=%0d exp=1", occupancy); end
        @(negedge clock); idle(); snoop_addr[0] = 32'h700; snoop_addr[1] = 32'h800;
        return_data_tag = 7; return_data = 64'h77; #1;
        checks++; if (snoop_hit !== 2'b01) begin errors++; $display("FAIL fl_snoop got=%b exp=01", snoop_hit); end
        @(posedge clock); #1;
        checks++; if (fill_valid !== 1'b1) begin errors++; $display("FAIL fl_fillv got=%0b exp=1", fill_valid); end
        checks++; if (fill_addr !== 32'h700) begin errors++; $display("FAIL fl_filla got=%h exp=700", fill_addr); end
        checks++; if (fill_is_prefetch !== 1'b1) begin errors++; $display("FAIL fl_fillpf got=%0b exp=1", fill_is_prefetch); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fl_occ0 got=%0d exp=0", occupancy); end
        snoop_addr = '0;
        $display("test_flush: ALLOC dropped, WAIT 0x700 filled as prefetch");
    endtask

    task automatic test_mid_reset();
        @(negedge clock); idle(); demand_valid = 1; demand_addr = 32'hA00;
        @(posedge clock);
        @(negedge clock); idle(); mem_req_accepted = 1; current_req_tag = 9;
        @(posedge clock); #1;
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL mr_occ1 got=%0d exp=1", occupancy); end
        @(negedge clock); idle(); reset = 1;
        @(posedge clock);
        @(negedge clock); reset = 0; return_data_tag = 9; return_data = 64'h99;
        @(posedge clock); #1;
        checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL mr_fill got=%0b exp=0", fill_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mr_occ0 got=%0d exp=0", occupancy); end
        $display("test_mid_reset: stale tag 9 ignored");
    endtask

    task automatic test_same_cycle();
        @(negedge clock); idle(); demand_valid = 1; demand_addr = 32'hB00; pf_valid = 1; pf_addr = 32'hB04; #1;
        checks++; if (demand_ready !== 1'b1) begin errors++; $display("FAIL sc_dready got=%0b exp=1", demand_ready); end
        checks++; if (pf_ready !== 1'b1) begin errors++; $display("FAIL sc_pready got=%0b exp=1", pf_ready); end
        @(posedge clock); #1;
        checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL sc_occ1 got=%0d exp=1", occupancy); end
        @(negedge clock); idle(); demand_valid = 1; demand_addr = 32'hC00; pf_valid = 1; pf_addr = 32'hD00; #1;
        checks++; if (pf_ready !== 1'b1) begin errors++; $display("FAIL sc_pready2 got=%0b exp=1", pf_ready); end
        @(posedge clock); #1;
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL sc_occ3 got=%0d exp=3", occupancy); end
        @(negedge clock); idle(); demand_valid = 1; demand_addr = 32'hE00; pf_valid = 1; pf_addr = 32'hF00; #1;
        checks++; if (demand_ready !== 1'b1) begin errors++; $display("FAIL sc_dready3 got=%0b exp=1", demand_ready); end
        checks++; if (pf_ready !== 1'b0) begin errors++; $display("FAIL sc_reserve got=%0b exp=0", pf_ready); end
        @(posedge clock); #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL sc_full got=%0b exp=1", full); end
        @(negedge clock); idle(); flush = 1;
        @(posedge clock); #1;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL sc_occ0 got=%0d exp=0", occupancy); end
        $display("test_same_cycle: same-line merge and reserve with demand slot");
    endtask

    initial begin
        test_reset();
        test_demand_fill();
        test_merge();
        test_pf_reserve();
        test_out_of_order();
        test_retry();
        test_flush();
        test_mid_reset();
        test_same_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
